vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares the single-port vector RAM between two requesters:
  - the CPU side, fed from the address decoder / store queue, issuing reads and writes;
  - the vector generator fetch unit, issuing reads only.
- Default priority goes to the vector generator so display timing holds.
- A burst limiter guarantees the CPU a slot so it cannot starve.
- Sits between the decoder's vector-RAM port and the BRAM primitive.

Parameters:
- ADDR_W, 13, vector RAM word-address width.
- MAX_VG_BURST, 4, maximum consecutive VG grants while a CPU request is waiting (range 1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- cpu_req  input  1  CPU access request, level; held with stable addr/we/wdata until cpu_gnt.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  8  CPU write data.
- cpu_gnt  output  1  access issued to BRAM this cycle.
- cpu_rdata  output  8  CPU read data, valid only while cpu_rvalid.
- cpu_rvalid  output  1  read response strobe.
- vg_req  input  1  VG read request, level; addr held until vg_gnt.
- vg_addr  input  ADDR_W  VG address.
- vg_gnt  output  1  VG access issued this cycle.
- vg_rdata  output  8  VG read data, valid only while vg_rvalid.
- vg_rvalid  output  1  VG read response strobe.
- bram_en  output  1  BRAM enable.
- bram_we  output  1  BRAM write enable.
- bram_addr  output  ADDR_W  BRAM address.
- bram_wdata  output  8  BRAM write data.
- bram_rdata  input  8  BRAM read data, registered in the BRAM, one cycle after the address.

Behaviour:
- Reset values: all grants, rvalids, bram_en, bram_we = 0; bram_addr, bram_wdata, cpu_rdata, vg_rdata = 0; streak counter = 0; FSM in IDLE.
- Arbitration is combinational within cycle N from the inputs and registered state. At most one grant per cycle.
- FSM states and transitions:
  - IDLE: neither requester granted last cycle.
  - VG_RUN: VG granted last cycle.
  - CPU_RUN: CPU granted last cycle.
  - Next state is VG_RUN on vg_gnt, CPU_RUN on cpu_gnt, otherwise IDLE.
- Grant rules:
  - Only vg_req → vg_gnt.
  - Only cpu_req → cpu_gnt.
  - Both requesting and streak < MAX_VG_BURST → vg_gnt.
  - Both requesting and streak == MAX_VG_BURST → cpu_gnt.
- Streak counter (4 bits):
  - Increments on each vg_gnt while cpu_req = 1.
  - Clears on cpu_gnt, and in any cycle with cpu_req = 0.
  - Saturates at MAX_VG_BURST.
- BRAM drive in grant cycle N:
  - bram_en = 1.
  - bram_addr = the granted requester's address.
  - bram_we = cpu_we on a CPU grant, 0 on a VG grant.
  - bram_wdata = cpu_wdata on a CPU write, otherwise 0.
  - All BRAM outputs are combinational from the grant; bram_en = 0 when no grant.
- Read response:
  - A 1-bit owner tag plus a read flag are registered at N.
  - In cycle N+1 exactly one of cpu_rvalid / vg_rvalid pulses for one cycle.
  - The matching rdata = bram_rdata (passthrough); the other requester's rdata is held at 0.
  - A CPU write produces no rvalid.
- Back-to-back: grants may issue every cycle. The response for N and a new grant at N+1 coexist with no bubble.
- A requester must drop req or present the next access in the cycle after its grant. A still-high req is treated as a new request.
- Reset mid-operation: the in-flight read response is discarded (no rvalid after reset release), and the streak is cleared.
- A write followed immediately by a read of the same address returns the new data. This relies on BRAM write-first mode; the block adds no bypass.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with a VG read in flight → all outputs 0 immediately, and no vg_rvalid after release.
- CPU only: cpu write addr 0x0123, data 0xA5, then read 0x0123 → cpu_gnt in both cycles; bram_we = 1 then 0; cpu_rvalid one cycle after the read grant with cpu_rdata = 0xA5.
- VG only: vg_req for 8 consecutive addresses 0x0000..0x0007 → 8 consecutive vg_gnt; vg_rvalid streams 8 cycles, each one cycle late, data matching preloaded RAM.
- Contention (MAX_VG_BURST = 4): vg_req and cpu_req both held high → grant pattern VG, VG, VG, VG, CPU, VG, VG, VG, VG, CPU.
- Streak clear: cpu_req drops after 3 VG grants, then reasserts → 4 further VG grants before the CPU is served.
- Response routing: CPU read at N, VG read at N+1 → cpu_rvalid at N+1, vg_rvalid at N+2, never both in one cycle, and the non-owner rdata = 0.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
// Shares the single-port vector RAM between the CPU (reads and writes) and the
// vector generator fetch unit (reads only). The vector generator wins by
// default so display timing holds. A burst limiter counts VG grants taken while
// the CPU waits, and it hands the CPU a slot once that count reaches
// MAX_VG_BURST. BRAM controls are driven combinationally in the grant cycle.
// The read response is routed back one cycle later, which matches the BRAM's
// registered read port.

module vram_port_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int MAX_VG_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,

  input  logic              vg_req,
  input  logic [ADDR_W-1:0] vg_addr,
  output logic              vg_gnt,
  output logic [7:0]        vg_rdata,
  output logic              vg_rvalid,

  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_wdata,
  input  logic [7:0]        bram_rdata
);

  // Last-cycle owner. This state also serves as the owner tag of the read response.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] VG_RUN  = 2'd1;
  localparam logic [1:0] CPU_RUN = 2'd2;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_VG_BURST);

  logic [1:0] state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       rdPend_q, rdPend_d;

  logic       cpuWins;
  logic       cpuGnt;
  logic       vgGnt;
  logic       burstExhausted;

  // Arbitration. VG wins unless the CPU has waited through a full burst.
  // While reset is held, both grants are gated off so the RAM stays idle.
  always_comb begin
    burstExhausted = (streak_q >= BURST_LIMIT);
    cpuWins        = cpu_req && (!vg_req || burstExhausted);
    cpuGnt         = !rst && cpuWins;
    vgGnt          = !rst && vg_req && !cpuWins;
  end

  assign cpu_gnt = cpuGnt;
  assign vg_gnt  = vgGnt;

  // BRAM port drive. The address, write enable and data all follow the grant.
  always_comb begin
    bram_en    = cpuGnt || vgGnt;
    bram_we    = cpuGnt && cpu_we;
    bram_addr  = '0;
    bram_wdata = 8'h00;
    if (cpuGnt) begin
      bram_addr = cpu_addr;
      if (cpu_we) begin
        bram_wdata = cpu_wdata;
      end
    end else if (vgGnt) begin
      bram_addr = vg_addr;
    end
  end

  // Next owner state, plus a flag that marks whether this access expects read data back.
  always_comb begin
    state_d  = IDLE;
    rdPend_d = 1'b0;
    if (vgGnt) begin
      state_d  = VG_RUN;
      rdPend_d = 1'b1;
    end else if (cpuGnt) begin
      state_d  = CPU_RUN;
      rdPend_d = !cpu_we;
    end
  end

  // Streak bookkeeping. Count VG grants only while the CPU waits, and saturate at the limit.
  always_comb begin
    streak_d = streak_q;
    if (!cpu_req || cpuGnt) begin
      streak_d = 4'd0;
    end else if (vgGnt && (streak_q < BURST_LIMIT)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // State registers. Reset drops any read in flight, so no rvalid follows the release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      rdPend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      rdPend_q <= rdPend_d;
    end
  end

  // Response routing. The owner of last cycle's read gets the BRAM data; the other side sees 0.
  always_comb begin
    cpu_rvalid = rdPend_q && (state_q == CPU_RUN);
    vg_rvalid  = rdPend_q && (state_q == VG_RUN);
    cpu_rdata  = cpu_rvalid ? bram_rdata : 8'h00;
    vg_rdata   = vg_rvalid  ? bram_rdata : 8'h00;
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Testbench for vram_port_arbiter
// The bench pairs the DUT with a write-first BRAM. A behavioural model predicts
// the grants, the BRAM drive and the read responses from its own memory image.
// A few directed scenarios carry literal expectations. Randomised traffic is
// then checked cycle by cycle against the model.

module tb_vram_port_arbiter;

  localparam int ADDR_W = 13;
  localparam int MAXB   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_wdata = 8'h00;
  logic              cpu_gnt, cpu_rvalid;
  logic [7:0]        cpu_rdata;
  logic              vg_req = 1'b0;
  logic [ADDR_W-1:0] vg_addr = '0;
  logic              vg_gnt, vg_rvalid;
  logic [7:0]        vg_rdata;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_wdata;
  logic [7:0]        bram_rdata = 8'h00;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] ram      [0:(1<<ADDR_W)-1];
  logic [7:0] modelMem [0:(1<<ADDR_W)-1];

  vram_port_arbiter #(.ADDR_W(ADDR_W), .MAX_VG_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vg_req(vg_req), .vg_addr(vg_addr), .vg_gnt(vg_gnt), .vg_rdata(vg_rdata),
    .vg_rvalid(vg_rvalid),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] preload(int a);
    return 8'(a * 7 + 3);
  endfunction

  // Preload both the bench BRAM and the model image with the same pattern.
  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      ram[a]      = preload(a);
      modelMem[a] = preload(a);
    end
  end

  // Write-first BRAM with a registered read port.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        ram[bram_addr] <= bram_wdata;
        bram_rdata     <= bram_wdata;
      end else begin
        bram_rdata <= ram[bram_addr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkString(input string name, input string act, input string exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                               input logic [7:0] cd, input logic vr, input logic [ADDR_W-1:0] va);
    @(posedge clk);
    #1;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    vg_req    = vr;
    vg_addr   = va;
  endtask

  // Behavioural model: one pending response at most, a streak count, and the memory image.
  int         streakM   = 0;
  bit         pendValid = 1'b0;
  bit         pendIsVg  = 1'b0;
  logic [7:0] pendData  = 8'h00;

  always @(negedge clk) begin
    bit               expCpu, expVg, expCpuRv, expVgRv;
    logic [ADDR_W-1:0] gAddr;
    if (rst) begin
      checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      checkOutput("rst_vg_gnt", 32'(vg_gnt), 32'd0);
      checkOutput("rst_bram_en", 32'(bram_en), 32'd0);
      checkOutput("rst_bram_we", 32'(bram_we), 32'd0);
      checkOutput("rst_bram_addr", 32'(bram_addr), 32'd0);
      checkOutput("rst_bram_wdata", 32'(bram_wdata), 32'd0);
      checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      checkOutput("rst_vg_rvalid", 32'(vg_rvalid), 32'd0);
      checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      checkOutput("rst_vg_rdata", 32'(vg_rdata), 32'd0);
      streakM   = 0;
      pendValid = 1'b0;
    end else begin
      expCpu = 1'b0;
      expVg  = 1'b0;
      if (vg_req && cpu_req) begin
        if (streakM == MAXB) expCpu = 1'b1;
        else                 expVg  = 1'b1;
      end else if (vg_req) begin
        expVg = 1'b1;
      end else if (cpu_req) begin
        expCpu = 1'b1;
      end
      gAddr    = expCpu ? cpu_addr : vg_addr;
      expCpuRv = pendValid && !pendIsVg;
      expVgRv  = pendValid && pendIsVg;

      checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(expCpu));
      checkOutput("vg_gnt", 32'(vg_gnt), 32'(expVg));
      checkOutput("bram_en", 32'(bram_en), 32'(expCpu || expVg));
      checkOutput("bram_we", 32'(bram_we), 32'(expCpu && cpu_we));
      if (expCpu || expVg) begin
        checkOutput("bram_addr", 32'(bram_addr), 32'(gAddr));
        checkOutput("bram_wdata", 32'(bram_wdata), (expCpu && cpu_we) ? 32'(cpu_wdata) : 32'd0);
      end
      checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(expCpuRv));
      checkOutput("vg_rvalid", 32'(vg_rvalid), 32'(expVgRv));
      checkOutput("cpu_rdata", 32'(cpu_rdata), expCpuRv ? 32'(pendData) : 32'd0);
      checkOutput("vg_rdata", 32'(vg_rdata), expVgRv ? 32'(pendData) : 32'd0);

      pendValid = 1'b0;
      if (expCpu && cpu_we) begin
        modelMem[cpu_addr] = cpu_wdata;
      end else if (expCpu || expVg) begin
        pendValid = 1'b1;
        pendIsVg  = expVg;
        pendData  = modelMem[gAddr];
      end

      if (!cpu_req || expCpu) streakM = 0;
      else if (expVg && streakM < MAXB) streakM = streakM + 1;
    end
  end

  initial begin
    string gp;
    string ch;
    bit    cg, vgs;
    bit    cpuLevels [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] CPU write then read");
    applyStimulus(1'b1, 1'b1, 13'h0123, 8'hA5, 1'b0, 13'h0);
    @(negedge clk);
    checkOutput("cpuw_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("cpuw_we", 32'(bram_we), 32'd1);
    checkOutput("cpuw_addr", 32'(bram_addr), 32'h123);
    checkOutput("cpuw_wdata", 32'(bram_wdata), 32'hA5);
    applyStimulus(1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 13'h0);
    @(negedge clk);
    checkOutput("cpur_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("cpur_we", 32'(bram_we), 32'd0);
    checkOutput("cpur_no_rvalid", 32'(cpu_rvalid), 32'd0);
    applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b0, 13'h0);
    @(negedge clk);
    checkOutput("cpur_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("cpur_rdata", 32'(cpu_rdata), 32'hA5);

    $display("[TB] VG streaming reads");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b1, 13'(i));
      @(negedge clk);
      checkOutput("vg_stream_gnt", 32'(vg_gnt), 32'd1);
      checkOutput("vg_stream_rvalid", 32'(vg_rvalid), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) checkOutput("vg_stream_rdata", 32'(vg_rdata), 32'(preload(i - 1)));
    end
    applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b0, 13'h0);
    @(negedge clk);
    checkOutput("vg_stream_last_rvalid", 32'(vg_rvalid), 32'd1);
    checkOutput("vg_stream_last_rdata", 32'(vg_rdata), 32'(preload(7)));

    $display("[TB] contention");
    gp = "";
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 13'h0200, 8'h00, 1'b1, 13'h0010);
      @(negedge clk);
      ch = vg_gnt ? "V" : (cpu_gnt ? "C" : "-");
      gp = {gp, ch};
    end
    checkString("contention_pattern", gp, "VVVVCVVVVC");
    applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b0, 13'h0);

    $display("[TB] streak clear");
    gp = "";
    for (int k = 0; k < 9; k++) begin
      applyStimulus(cpuLevels[k], 1'b0, 13'h0200, 8'h00, 1'b1, 13'h0010);
      @(negedge clk);
      ch = vg_gnt ? "V" : (cpu_gnt ? "C" : "-");
      gp = {gp, ch};
    end
    checkString("streak_clear_pattern", gp, "VVVVVVVVC");
    applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b0, 13'h0);

    $display("[TB] response routing");
    applyStimulus(1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 13'h0);
    @(negedge clk);
    checkOutput("route_cpu_gnt", 32'(cpu_gnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b1, 13'h0005);
    @(negedge clk);
    checkOutput("route_vg_gnt", 32'(vg_gnt), 32'd1);
    checkOutput("route_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("route_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    checkOutput("route_vg_rvalid0", 32'(vg_rvalid), 32'd0);
    checkOutput("route_vg_rdata0", 32'(vg_rdata), 32'd0);
    applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b0, 13'h0);
    @(negedge clk);
    checkOutput("route_vg_rvalid", 32'(vg_rvalid), 32'd1);
    checkOutput("route_vg_rdata", 32'(vg_rdata), 32'(preload(5)));
    checkOutput("route_cpu_rvalid0", 32'(cpu_rvalid), 32'd0);
    checkOutput("route_cpu_rdata0", 32'(cpu_rdata), 32'd0);

    $display("[TB] reset with a VG read in flight");
    applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b1, 13'h0003);
    @(negedge clk);
    checkOutput("rstfl_vg_gnt", 32'(vg_gnt), 32'd1);
    @(posedge clk);
    #1 vg_addr = 13'h0004;
    #2 rst = 1'b1;
    #1;
    checkOutput("rstfl_vg_gnt0", 32'(vg_gnt), 32'd0);
    checkOutput("rstfl_bram_en0", 32'(bram_en), 32'd0);
    checkOutput("rstfl_vg_rvalid0", 32'(vg_rvalid), 32'd0);
    checkOutput("rstfl_vg_rdata0", 32'(vg_rdata), 32'd0);
    vg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rstfl_no_rvalid", 32'(vg_rvalid), 32'd0);
    end

    $display("[TB] randomised traffic");
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      cg  = cpu_gnt;
      vgs = vg_gnt;
      @(posedge clk);
      #1;
      if (!cpu_req || cg) begin
        cpu_req   = ($urandom_range(0, 99) < 55);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 13'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom);
      end
      if (!vg_req || vgs) begin
        vg_req  = ($urandom_range(0, 99) < 70);
        vg_addr = 13'($urandom_range(0, 63));
      end
    end
    applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, 1'b0, 13'h0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
